gate_sweep_checker: RTL and testbench

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

---
 rtl/gate_sweep_pkg.sv | 59 +++++
 rtl/gate_sweep_dwell_cnt.sv | 32 +++
 rtl/gate_sweep_checker.sv | 126 ++++++++++++
 tb/tb_gate_sweep_checker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg -- shared definitions for the gate sweep checker.
//   * op encoding constants for the expected gate function
//   * FSM state type
//   * op_is_reserved()  : flags op codes with no defined function
//   * expected_value()  : reduction of the low n_in bits of a vector by op
package gate_sweep_pkg;

  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_NOR  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  // Widest supported gate; vectors are zero-extended to this width.
  localparam int MAX_N_IN = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_e;

  function automatic logic op_is_reserved(input logic [2:0] op);
    return op > OP_XNOR;
  endfunction

  // Only the low n_in bits take part; the rest of vec is ignored.
  function automatic logic expected_value(input logic [2:0]          op,
                                          input logic [MAX_N_IN-1:0] vec,
                                          input int                  n_in);
    logic all_ones;
    logic any_one;
    logic parity;
    logic result;
    all_ones = 1'b1;
    any_one  = 1'b0;
    parity   = 1'b0;
    for (int i = 0; i < MAX_N_IN; i++) begin
      if (i < n_in) begin
        all_ones = all_ones & vec[i];
        any_one  = any_one | vec[i];
        parity   = parity ^ vec[i];
      end
    end
    case (op)
      OP_NAND: result = ~all_ones;
      OP_AND:  result = all_ones;
      OP_NOR:  result = ~any_one;
      OP_OR:   result = any_one;
      OP_XOR:  result = parity;
      OP_XNOR: result = ~parity;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/gate_sweep_dwell_cnt.sv
// gate_sweep_dwell_cnt -- dwell cycle counter for the gate sweep checker.
// Counts up every cycle while clr is low; tc flags the last DRIVE cycle of a
// vector (count DWELL-2), so DRIVE lasts DWELL-1 cycles before SAMPLE.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (has priority over counting)
//   tc         : terminal count reached
module gate_sweep_dwell_cnt #(
  parameter int DWELL = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc
);

  logic [7:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples values from before the edge regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tc = (cnt == 8'(DWELL - 2));

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker -- exhaustively sweeps all 2^N_IN input vectors into a
// gate under test, holding each for DWELL cycles, and compares the gate output
// with the expected function selected by op (latched at start).
//   clk, rst_n  : clock, asynchronous active-low reset
//   start, stop : begin a sweep (ignored while busy) / abort a sweep
//   op          : 0 NAND, 1 AND, 2 NOR, 3 OR, 4 XOR, 5 XNOR, 6..7 reserved
//   dut_out     : gate-under-test output
//   stim        : vector driven to the gate under test
//   busy, done  : sweep in progress / one-cycle completion pulse
//   pass        : last completed sweep had no mismatches
//   err_cnt     : mismatch count of the current or last sweep (saturating)
//   first_fail  : stim value of the first mismatch of the sweep
// Optional feature: define GATE_SWEEP_FAIL_CAPTURE_EN to build the
// first_fail capture register; otherwise first_fail is tied to 0.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int DWELL = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic [2:0]      op,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail
);

  localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};

  state_e     state_q, state_d;
  logic [2:0] op_q;
  logic       dwell_tc;
  logic       launch;
  logic       sample_now;
  logic       mismatch;

  assign launch     = (state_q == S_IDLE) && start && !stop;
  // A stop during SAMPLE discards that cycle's comparison.
  assign sample_now = (state_q == S_SAMPLE) && !stop;
  assign mismatch   = op_is_reserved(op_q) ||
                      (dut_out != expected_value(op_q, MAX_N_IN'(stim), N_IN));

  // Counter restarts whenever DRIVE is (re)entered.
  gate_sweep_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != S_DRIVE),
    .tc    (dwell_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so that no path leaves it
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (launch) state_d = S_DRIVE;
      S_DRIVE: begin
        if (stop)          state_d = S_IDLE;
        else if (dwell_tc) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (stop)       state_d = S_IDLE;
        else if (&stim) state_d = S_DONE;
        else            state_d = S_DRIVE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: op_q is reset along with the other registers even though it is
  // reloaded at every start, so no register ever powers up undefined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim    <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
      op_q    <= OP_NAND;
    end else if (launch) begin
      stim    <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
      op_q    <= op;
    end else if (sample_now) begin
      if (mismatch && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + (N_IN+1)'(1);
      if (!(&stim))                         stim    <= stim + N_IN'(1);
    end else if (state_q == S_DONE) begin
      // err_cnt already includes the final sample by the time DONE is reached.
      pass <= (err_cnt == '0);
    end
  end

`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
  logic [N_IN-1:0] first_fail_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_q <= '0;
    end else if (launch) begin
      first_fail_q <= '0;
    end else if (sample_now && mismatch && (err_cnt == '0)) begin
      first_fail_q <= stim;
    end
  end

  assign first_fail = first_fail_q;
`else
  assign first_fail = '0;
`endif

  assign busy = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench for gate_sweep_checker. Three instances cover the
// configurations of interest:
//   a : N_IN=2, DWELL=10, op NAND, gate ideal / stuck-at-1 / stuck-at-0
//   b : N_IN=4, DWELL=2,  op XOR, ideal gate, start re-pulsed and op changed
//   c : N_IN=3, DWELL=3,  reserved op 6, random gate output
// Expected sweep results are pushed to a scoreboard queue at start and
// popped when the sweep finishes (or is aborted).
module tb_gate_sweep_checker;

`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  typedef struct {
    int err;
    int pass;
    int ff;
    int cycles;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance a ----------------
  logic       start_a = 1'b0, stop_a = 1'b0;
  logic [2:0] op_a = 3'd0;
  int         mode_a = 0;  // 0 ideal NAND, 1 stuck-at-1, 2 stuck-at-0
  logic       dut_out_a;
  logic [1:0] stim_a, ff_a;
  logic       busy_a, done_a, pass_a;
  logic [2:0] err_a;
  int         done_cnt_a = 0;

  assign dut_out_a = (mode_a == 0) ? ~(&stim_a) : (mode_a == 1);

  gate_sweep_checker #(.N_IN(2), .DWELL(10)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .op(op_a),
    .dut_out(dut_out_a), .stim(stim_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a), .first_fail(ff_a)
  );

  always @(negedge clk) if (done_a === 1'b1) done_cnt_a++;

  // ---------------- instance b ----------------
  logic       start_b = 1'b0, stop_b = 1'b0;
  logic [2:0] op_b = 3'd4;
  logic       dut_out_b;
  logic [3:0] stim_b, ff_b;
  logic       busy_b, done_b, pass_b;
  logic [4:0] err_b;

  assign dut_out_b = ^stim_b;

  gate_sweep_checker #(.N_IN(4), .DWELL(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .op(op_b),
    .dut_out(dut_out_b), .stim(stim_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_b), .first_fail(ff_b)
  );

  // ---------------- instance c ----------------
  logic       start_c = 1'b0, stop_c = 1'b0;
  logic [2:0] op_c = 3'd6;
  logic       dut_out_c = 1'b0;
  logic [2:0] stim_c, ff_c;
  logic       busy_c, done_c, pass_c;
  logic [3:0] err_c;

  always @(negedge clk) dut_out_c = 1'($urandom_range(0, 1));

  gate_sweep_checker #(.N_IN(3), .DWELL(3)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .stop(stop_c), .op(op_c),
    .dut_out(dut_out_c), .stim(stim_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .err_cnt(err_c), .first_fail(ff_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference for instance a: 2-input NAND against the selected gate fault.
  task automatic nand_model(input int mode, output int errs, output int ff);
    logic exp_bit, obs_bit;
    errs = 0;
    ff   = 0;
    for (int v = 0; v < 4; v++) begin
      exp_bit = (v != 3);
      obs_bit = (mode == 0) ? exp_bit : (mode == 1);
      if (obs_bit != exp_bit) begin
        if (errs == 0 && CAP_EN) ff = v;
        errs++;
      end
    end
  endtask

  task automatic start_pulse_a();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
  endtask

  task automatic sweep_a(input int mode);
    int   errs, ff, k;
    exp_t e;
    mode_a = mode;
    nand_model(mode, errs, ff);
    sb.push_back('{errs, (errs == 0) ? 1 : 0, ff, 40});
    start_pulse_a();
    check("a_stim_v0", 32'(stim_a), 32'd0);
    check("a_busy", 32'(busy_a), 32'd1);
    k = 0;
    while (k < 60) begin
      @(posedge clk);
      #1;
      k++;
      if (done_a === 1'b1) break;
      if (k % 10 == 0) check("a_stim_step", 32'(stim_a), 32'(k / 10));
    end
    e = sb.pop_front();
    check("a_done_latency", 32'(k), 32'(e.cycles));
    check("a_err_cnt", 32'(err_a), 32'(e.err));
    @(posedge clk);
    #1;
    check("a_pass", 32'(pass_a), 32'(e.pass));
    check("a_first_fail", 32'(ff_a), 32'(e.ff));
    check("a_idle_after_done", 32'({busy_a, done_a}), 32'd0);
    check("a_stim_hold", 32'(stim_a), 32'd3);
  endtask

  initial begin
    int   k, d0;
    exp_t e;

    // Reset values while rst_n is held low.
    #12;
    check("rst_a", 32'({stim_a, busy_a, done_a, pass_a, err_a, ff_a}), 32'd0);
    check("rst_b", 32'({stim_b, busy_b, done_b, pass_b, err_b, ff_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ideal NAND, then stuck-at-1 gate.
    sweep_a(0);
    sweep_a(1);

    // Abort during vector 2 with the gate stuck at 0: two samples counted.
    mode_a = 2;
    sb.push_back('{2, 0, 0, 0});
    d0 = done_cnt_a;
    start_pulse_a();
    repeat (23) @(posedge clk);
    #1;
    stop_a = 1'b1;
    @(posedge clk);
    #1;
    stop_a = 1'b0;
    check("a_stop_busy", 32'(busy_a), 32'd0);
    repeat (15) @(posedge clk);
    #1;
    e = sb.pop_front();
    check("a_stop_no_done", 32'(done_cnt_a - d0), 32'd0);
    check("a_stop_err", 32'(err_a), 32'(e.err));
    check("a_stop_pass", 32'(pass_a), 32'(e.pass));
    check("a_stop_ff", 32'(ff_a), 32'(e.ff));
    check("a_stop_stim", 32'(stim_a), 32'd2);

    // start and stop together in IDLE: stop wins.
    @(negedge clk);
    start_a = 1'b1;
    stop_a  = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    stop_a  = 1'b0;
    check("a_start_stop_idle", 32'(busy_a), 32'd0);

    // Asynchronous reset between edges during vector 1.
    mode_a = 0;
    start_pulse_a();
    repeat (13) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("a_async_rst", 32'({stim_a, busy_a, done_a, pass_a, err_a, ff_a}), 32'd0);
    #1;
    rst_n = 1'b1;
    sweep_a(0);

    // Instance b: 16 vectors, 2 cycles each; start re-pulsed and op changed
    // mid-sweep must have no effect.
    sb.push_back('{0, 1, 0, 32});
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    k = 0;
    while (k < 60) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 5) op_b = 3'd0;
      if (k == 7) start_b = 1'b1;
      if (k == 8) start_b = 1'b0;
      if (k == 10) check("b_stim_v5", 32'(stim_b), 32'd5);
      if (done_b === 1'b1) break;
    end
    e = sb.pop_front();
    check("b_done_latency", 32'(k), 32'(e.cycles));
    check("b_err_cnt", 32'(err_b), 32'(e.err));
    @(posedge clk);
    #1;
    check("b_pass", 32'(pass_b), 32'(e.pass));
    check("b_stim_hold", 32'(stim_b), 32'd15);
    op_b = 3'd4;

    // Instance c: reserved op, every sample is a mismatch.
    sb.push_back('{8, 0, 0, 24});
    @(negedge clk);
    start_c = 1'b1;
    @(posedge clk);
    #1;
    start_c = 1'b0;
    k = 0;
    while (k < 60) begin
      @(posedge clk);
      #1;
      k++;
      if (done_c === 1'b1) break;
    end
    e = sb.pop_front();
    check("c_done_latency", 32'(k), 32'(e.cycles));
    check("c_err_cnt", 32'(err_c), 32'(e.err));
    @(posedge clk);
    #1;
    check("c_pass", 32'(pass_c), 32'(e.pass));
    check("c_first_fail", 32'(ff_c), 32'(e.ff));

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
